// File: rtl/write_buffer.sv
// Posted-write buffer: DEPTH-entry FIFO drained to the shared bus by an IDLE/REQ/XFER FSM.
// Define WRITE_BUFFER_FWD_EN to compile in store-to-load forwarding on rd_addr.
module write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_req,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        wr_wait,
  input  logic [31:0] rd_addr,
  output logic        rd_hit,
  output logic [31:0] rd_data,
  output logic        empty,
  output logic        bus_req,
  input  logic        bus_ack,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_rd,
  output logic        bus_wr,
  input  logic        bus_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic [31:0]   addr_mem_q [DEPTH];
  logic [31:0]   addr_mem_d [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic [31:0]   data_mem_d [DEPTH];
  logic          bus_req_q, bus_req_d;
  logic          bus_wr_q, bus_wr_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic          push;
  logic          pop;

  // Full is judged on the registered count, so a pop in the same cycle cannot admit a push.
  assign wr_wait   = (count_q == FULL_CNT);
  assign empty     = (count_q == {(PW+1){1'b0}});
  assign bus_rd    = 1'b0;
  assign bus_req   = bus_req_q;
  assign bus_wr    = bus_wr_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

  always_comb begin
    push       = wr_req && !wr_wait;
    pop        = (state_q == XFER) && bus_ready;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    state_d    = state_q;
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;

    if (push) begin
      addr_mem_d[tail_q] = wr_addr;
      data_mem_d[tail_q] = wr_data;
      tail_d             = tail_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      tail_d = tail_q;
    end

    if (pop) begin
      head_d = head_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      head_d = head_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + {{PW{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{PW{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase

    // XFER always falls back to IDLE so bus_req drops for a cycle between transfers.
    case (state_q)
      IDLE: begin
        if (count_q != {(PW+1){1'b0}}) state_d = REQ;
        else                           state_d = IDLE;
      end
      REQ: begin
        if (bus_ack) state_d = XFER;
        else         state_d = REQ;
      end
      XFER: begin
        if (bus_ready) state_d = IDLE;
        else           state_d = XFER;
      end
      default: state_d = IDLE;
    endcase

    // Head slot is never rewritten while REQ/XFER hold it, so the registered copy is safe here.
    bus_req_d = (state_d != IDLE);
    bus_wr_d  = (state_d == XFER);
    if (state_d == XFER) begin
      bus_addr_d  = addr_mem_q[head_q];
      bus_wdata_d = data_mem_q[head_q];
    end else begin
      bus_addr_d  = 32'h0;
      bus_wdata_d = 32'h0;
    end
  end

  // Control state and registered bus outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      head_q      <= {PW{1'b0}};
      tail_q      <= {PW{1'b0}};
      count_q     <= {(PW+1){1'b0}};
      bus_req_q   <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      bus_req_q   <= bus_req_d;
      bus_wr_q    <= bus_wr_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  // Entry storage carries no reset; only slots covered by count are ever observed.
  always_ff @(posedge clk) begin
    addr_mem_q <= addr_mem_d;
    data_mem_q <= data_mem_d;
  end

`ifdef WRITE_BUFFER_FWD_EN
  logic [PW-1:0] fwd_idx;

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    rd_hit  = 1'b0;
    rd_data = 32'h0;
    fwd_idx = {PW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PW'(i);
      if (((PW+1)'(i) < count_q) && (addr_mem_q[fwd_idx] == rd_addr)) begin
        rd_hit  = 1'b1;
        rd_data = data_mem_q[fwd_idx];
      end else begin
        rd_hit  = rd_hit;
        rd_data = rd_data;
      end
    end
  end
`else
  logic unused_rd_addr;

  assign unused_rd_addr = ^rd_addr;
  assign rd_hit         = 1'b0;
  assign rd_data        = 32'h0;
`endif

endmodule

// File: tb/tb_write_buffer.sv
// Self-checking bench for write_buffer: directed table, corner sequences, then random traffic
// checked every cycle against a queue-based model of the buffer and bus handshake.
module tb_write_buffer;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_wait;
  logic [31:0] rd_addr;
  logic        rd_hit;
  logic [31:0] rd_data;
  logic        empty;
  logic        bus_req;
  logic        bus_ack;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_rd;
  logic        bus_wr;
  logic        bus_ready;

  write_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_wait(wr_wait), .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_data(rd_data),
    .empty(empty), .bus_req(bus_req), .bus_ack(bus_ack), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_ready(bus_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        bus_ack;
    logic        bus_ready;
    logic        e_wait;
    logic        e_empty;
    logic        e_req;
    logic        e_wr;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
  } vec_t;

  // Model: queue of posted writes plus the drain phase (0 idle, 1 requesting, 2 transferring).
  ent_t mq[$];
  int   ph;
  int   nvec;
  int   nmis;
  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    ph = 0;
  endtask

  task automatic check_model();
    logic        e_hit;
    logic [31:0] e_rdata;
    logic [31:0] e_a;
    logic [31:0] e_d;
    e_hit   = 1'b0;
    e_rdata = 32'h0;
    e_a     = 32'h0;
    e_d     = 32'h0;
`ifdef WRITE_BUFFER_FWD_EN
    foreach (mq[i]) begin
      if (mq[i].a == rd_addr) begin
        e_hit   = 1'b1;
        e_rdata = mq[i].d;
      end
    end
`endif
    if (ph == 2 && mq.size() > 0) begin
      e_a = mq[0].a;
      e_d = mq[0].d;
    end
    chk("m_wr_wait", {31'h0, wr_wait}, {31'h0, mq.size() == DEPTH});
    chk("m_empty", {31'h0, empty}, {31'h0, mq.size() == 0});
    chk("m_bus_req", {31'h0, bus_req}, {31'h0, ph != 0});
    chk("m_bus_wr", {31'h0, bus_wr}, {31'h0, ph == 2});
    chk("m_bus_rd", {31'h0, bus_rd}, 32'h0);
    chk("m_bus_addr", bus_addr, e_a);
    chk("m_bus_wdata", bus_wdata, e_d);
    chk("m_rd_hit", {31'h0, rd_hit}, {31'h0, e_hit});
    chk("m_rd_data", rd_data, e_rdata);
  endtask

  // One clock: the model applies the same edge the DUT sees, then outputs are compared 1ns later.
  task automatic step();
    bit   push;
    bit   pop;
    int   nph;
    ent_t e;
    @(posedge clk);
    push = wr_req && (mq.size() < DEPTH);
    pop  = (ph == 2) && bus_ready;
    nph  = ph;
    case (ph)
      0:       if (mq.size() > 0) nph = 1;
      1:       if (bus_ack) nph = 2;
      default: if (bus_ready) nph = 0;
    endcase
    if (pop) mq.delete(0);
    if (push) begin
      e.a = wr_addr;
      e.d = wr_data;
      mq.push_back(e);
    end
    ph = nph;
    #1;
    check_model();
  endtask

  task automatic post(input logic [31:0] a, input logic [31:0] d);
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_req  = 1'b0;
  endtask

  task automatic wait_xfer(input string nm);
    int n;
    n = 0;
    while (bus_wr !== 1'b1 && n < 12) begin
      step();
      n++;
    end
    chk(nm, {31'h0, bus_wr}, 32'h1);
  endtask

  initial begin
    logic [31:0] seen[$];
    logic [31:0] exp_order[4];
    int          steps;
    bit          prev_wr;
    bit          pop_checked;

    nvec = 0;
    nmis = 0;
    model_reset();
    rst = 1'b1; wr_req = 1'b0; wr_addr = 32'h0; wr_data = 32'h0;
    rd_addr = 32'h0; bus_ack = 1'b0; bus_ready = 1'b0;

    // Reset state, visible before any clock edge.
    #2;
    check_model();
    chk("rst_empty", {31'h0, empty}, 32'h1);
    chk("rst_bus_req", {31'h0, bus_req}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single write: 0x100/DEADBEEF reaches the bus on the 3rd cycle after the post.
    tbl[0] = '{1'b1, 32'h100, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[1] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0};
    tbl[2] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[4] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      wr_req    = tbl[i].wr_req;
      wr_addr   = tbl[i].wr_addr;
      wr_data   = tbl[i].wr_data;
      bus_ack   = tbl[i].bus_ack;
      bus_ready = tbl[i].bus_ready;
      step();
      chk($sformatf("t%0d_wait", i), {31'h0, wr_wait}, {31'h0, tbl[i].e_wait});
      chk($sformatf("t%0d_empty", i), {31'h0, empty}, {31'h0, tbl[i].e_empty});
      chk($sformatf("t%0d_req", i), {31'h0, bus_req}, {31'h0, tbl[i].e_req});
      chk($sformatf("t%0d_wr", i), {31'h0, bus_wr}, {31'h0, tbl[i].e_wr});
      chk($sformatf("t%0d_addr", i), bus_addr, tbl[i].e_addr);
      chk($sformatf("t%0d_wdata", i), bus_wdata, tbl[i].e_wdata);
    end
    wr_req = 1'b0;

    // Fill and order: 5th post is refused, entries leave in order, wr_wait falls after first pop.
    bus_ack   = 1'b0;
    bus_ready = 1'b1;
    exp_order = '{32'h0, 32'h4, 32'h8, 32'hC};
    for (int i = 0; i < 4; i++) post(exp_order[i], 32'hA0 + 32'(i));
    chk("fill_wait", {31'h0, wr_wait}, 32'h1);
    post(32'h10, 32'hA4);
    chk("fill_wait5", {31'h0, wr_wait}, 32'h1);
    bus_ack     = 1'b1;
    prev_wr     = 1'b0;
    pop_checked = 1'b0;
    steps       = 0;
    while (seen.size() < 4 && steps < 30) begin
      step();
      steps++;
      if (prev_wr && !pop_checked) begin
        chk("fill_wait_fall", {31'h0, wr_wait}, 32'h0);
        pop_checked = 1'b1;
      end
      if (bus_wr === 1'b1) begin
        if (!pop_checked) chk("fill_wait_hold", {31'h0, wr_wait}, 32'h1);
        seen.push_back(bus_addr);
      end
      prev_wr = (bus_wr === 1'b1);
    end
    chk("fill_count", 32'(seen.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fill_order%0d", i), (i < seen.size()) ? seen[i] : 32'hFFFFFFFF, exp_order[i]);
    end
    for (int i = 0; i < 4; i++) step();
    chk("fill_drained", {31'h0, empty}, 32'h1);

    // Ready stall: head held for 6 cycles, then pop and a one-cycle bus_req gap.
    bus_ack   = 1'b1;
    bus_ready = 1'b0;
    post(32'h40, 32'h1111);
    post(32'h44, 32'h2222);
    wait_xfer("stall_reach");
    for (int i = 0; i < 6; i++) begin
      step();
      chk("stall_addr", bus_addr, 32'h40);
      chk("stall_wdata", bus_wdata, 32'h1111);
      chk("stall_wr", {31'h0, bus_wr}, 32'h1);
    end
    bus_ready = 1'b1;
    step();
    chk("stall_pop_req", {31'h0, bus_req}, 32'h0);
    bus_ready = 1'b0;
    step();
    chk("stall_rereq", {31'h0, bus_req}, 32'h1);
    bus_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("stall_drained", {31'h0, empty}, 32'h1);

    // Forwarding: youngest of two writes to 0x20 is returned while the bus is stalled.
    bus_ack = 1'b0;
    rd_addr = 32'h20;
    post(32'h20, 32'h1);
    post(32'h20, 32'h2);
`ifdef WRITE_BUFFER_FWD_EN
    chk("fwd_hit", {31'h0, rd_hit}, 32'h1);
    chk("fwd_data", rd_data, 32'h2);
`else
    chk("fwd_hit", {31'h0, rd_hit}, 32'h0);
    chk("fwd_data", rd_data, 32'h0);
`endif

    // Reset mid-transfer with 3 entries: outputs clear without a clock edge.
    post(32'h30, 32'h3);
    bus_ack   = 1'b1;
    bus_ready = 1'b0;
    wait_xfer("rst_reach");
    chk("rst_pre_cnt", 32'(mq.size()), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_wr", {31'h0, bus_wr}, 32'h0);
    chk("rst_mid_req", {31'h0, bus_req}, 32'h0);
    chk("rst_mid_empty", {31'h0, empty}, 32'h1);
    chk("rst_mid_hit", {31'h0, rd_hit}, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    bus_ack = 1'b0;
    step();

    // Random traffic against the model, with rd_addr drawn from the same small address pool.
    for (int i = 0; i < 400; i++) begin
      wr_req    = ($urandom_range(0, 1) == 1);
      wr_addr   = 32'($urandom_range(0, 7)) << 2;
      wr_data   = $urandom;
      bus_ack   = ($urandom_range(0, 2) != 0);
      bus_ready = ($urandom_range(0, 2) != 0);
      rd_addr   = 32'($urandom_range(0, 7)) << 2;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/write_buffer.md
WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, meaning the number of posted-write entries (power of two, 2..16).
REQ-002 SHALL provide port clk  in  1  system clock; all state changes on the rising edge.
REQ-003 SHALL provide port rst  in  1  reset; asynchronous and active-high.
REQ-004 SHALL provide port wr_req  in  1  DCache posts a write this cycle.
REQ-005 SHALL provide port wr_addr  in  32  write address.
REQ-006 SHALL provide port wr_data  in  32  write data.
REQ-007 SHALL provide port wr_wait  out  1  buffer full; the post is refused this cycle.
REQ-008 SHALL provide port rd_addr  in  32  DCache lookup address for forwarding.
REQ-009 SHALL provide port rd_hit  out  1  rd_addr matches a buffered entry.
REQ-010 SHALL provide port rd_data  out  32  forwarded data.
REQ-011 SHALL provide port empty  out  1  no entries are buffered.
REQ-012 SHALL provide the bus-side ports with these directions and widths:
- bus_req  out  1
- bus_ack  in  1
- bus_addr  out  32
- bus_wdata  out  32
- bus_rd  out  1
- bus_wr  out  1
- bus_ready  in  1
These ports SHALL follow the system shared-bus protocol.

Function
REQ-013 SHALL hold DEPTH entries of {addr[31:0], data[31:0]} in a circular FIFO with head/tail pointers wrapping modulo DEPTH and a count of 0..DEPTH.
REQ-014 SHALL assert wr_wait combinationally when count==DEPTH, based on the registered count (a same-cycle drain does not clear it).
REQ-015 SHALL enqueue {wr_addr, wr_data} at the tail on a rising edge with wr_req=1 and wr_wait=0.
REQ-016 SHALL leave the FIFO unchanged when wr_req=1 and wr_wait=1.
REQ-017 SHALL assert empty when count==0.
REQ-018 SHALL implement the drain FSM states IDLE, REQ and XFER with these transitions:
- IDLE -> REQ when count>0.
- REQ -> XFER when bus_ack=1.
- XFER -> IDLE on bus_ready=1, popping the head in the same edge.
REQ-019 SHALL assert bus_req in REQ and XFER only.
REQ-020 SHALL drive the bus-side outputs as follows:
- In XFER: bus_wr=1, bus_addr=head addr, bus_wdata=head data.
- In all other states: bus_addr, bus_wdata and bus_wr at 0, as required by the OR-combined bus.
REQ-021 SHALL tie bus_rd to 0 permanently.
REQ-022 SHALL release bus_req for at least one cycle (IDLE) after every transfer so the arbiter may grant another master.
REQ-023 SHALL give the minimum latency of 3 edges from an enqueue edge to the first bus_wr=1 cycle when the buffer was empty and bus_ack arrives immediately.
REQ-024 SHALL keep count unchanged on a simultaneous push and pop, write the tail and read the head correctly, and allow a push into the slot freed by the pop only on the next cycle.
REQ-025 SHALL hold XFER and the head entry stable while bus_ready=0, with no timeout.
REQ-026 SHALL remain in XFER and keep driving the bus if bus_ack drops during XFER.
REQ-027 SHALL retire entries strictly in FIFO order, with no coalescing and no reordering.

Reset
REQ-028 SHALL, on rst=1 and independent of clk, clear count and both pointers, enter IDLE and drive these outputs:
- wr_wait=0, empty=1, rd_hit=0, rd_data=0.
- bus_req=0, bus_addr=0, bus_wdata=0, bus_rd=0, bus_wr=0.
REQ-029 SHALL, on reset asserted mid-XFER, abandon the transfer and discard all buffered entries.
REQ-030 SHALL leave the entry storage contents undefined after reset; they are never observable because all valid state is cleared.

Configuration
REQ-031 SHALL compile store-to-load forwarding in only when the macro WRITE_BUFFER_FWD_EN is defined.
REQ-032 SHALL, with WRITE_BUFFER_FWD_EN defined, compare rd_addr combinationally against all valid entries (including the head in XFER) and drive rd_hit=1 and rd_data=data of the youngest matching entry.
REQ-033 SHALL, with WRITE_BUFFER_FWD_EN undefined, tie rd_hit=0 and rd_data=0 permanently and include no comparators.

Verification
REQ-034 SHALL verify the single write: post {0x100, 0xDEADBEEF} with bus_ack held at 1 and bus_ready at 1 -> bus_wr=1 with bus_addr=0x100 and bus_wdata=0xDEADBEEF on the 3rd cycle after the post, then empty=1.
REQ-035 SHALL verify fill and order: with DEPTH=4 and bus_ack=0, post 5 writes to 0x0, 0x4, 0x8, 0xC, 0x10 -> wr_wait=1 on the 5th post; after granting, the bus sees 0x0, 0x4, 0x8, 0xC in order, and wr_wait falls the cycle after the first pop.
REQ-036 SHALL verify a ready stall: with bus_ready=0 for 6 cycles in XFER -> bus_addr and bus_wdata stay constant and count is unchanged; on bus_ready=1 the entry pops and bus_req drops for 1 cycle.
REQ-037 SHALL verify forwarding, with WRITE_BUFFER_FWD_EN defined: post {0x20, 1} then {0x20, 2} and stall the bus -> with rd_addr=0x20, rd_hit=1 and rd_data=2; with WRITE_BUFFER_FWD_EN undefined, rd_hit=0.
REQ-038 SHALL verify reset mid-transfer: assert rst during XFER with 3 entries buffered -> bus_wr=0 and bus_req=0 immediately, and empty=1 without waiting for a clock edge.
